// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF measurement controller.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: FSM state enum, default parameter values, one-hot decode helper.
package ro_puf_pkg;

  localparam int DEF_NUM_RO    = 32;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_WINDOW    = 1024;
  localparam int DEF_SETTLE    = 8;
  localparam int DEF_RESP_BITS = 8;

  // Upper bound on bank size the one-hot helper can decode (NUM_RO <= 256).
  localparam int MAX_SEL_W = 8;
  localparam int MAX_RO    = 1 << MAX_SEL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_e;

  // Full-width decode; callers truncate to their bank size with a size cast.
  function automatic logic [MAX_RO-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [MAX_RO-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Counts rising edges of one asynchronous RO signal in the clk domain, saturating.
// Latency: an input edge reaches the count 3 clk later (2-flop sync + edge flop).
// Backpressure: none; clr_i has priority over en_i.
// Ports: clk, rst_n (sync, active-low), ro_i (async), clr_i, en_i, cnt_o.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  assign rise  = sync2_q & ~prev_q;
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ro_puf_meas_ctrl.sv
// RO-PUF measurement controller: per response bit, enables one RO pair, counts
// edges of both banks over a fixed window and records a > b and a == b.
// Latency: start -> done = RESP_BITS*(SETTLE+WINDOW+1)+1 clk; start ignored unless idle.
// Ports: clk, rst_n, start, challenge in; ro_a/ro_b async RO banks in;
//        ro_en, busy, done, response, tie_mask, dbg_cnt_a, dbg_cnt_b out.
module ro_puf_meas_ctrl
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO    = DEF_NUM_RO,
  parameter int SEL_W     = $clog2(NUM_RO),
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int RESP_BITS = DEF_RESP_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SEL_W-1:0]     challenge,
  input  logic [NUM_RO-1:0]    ro_a,
  input  logic [NUM_RO-1:0]    ro_b,
  output logic [NUM_RO-1:0]    ro_en,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [RESP_BITS-1:0] tie_mask,
  output logic [CNT_W-1:0]     dbg_cnt_a,
  output logic [CNT_W-1:0]     dbg_cnt_b
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     chal_q, k_q, idx;
  logic [TMR_W-1:0]     tmr_q;
  logic [RESP_BITS-1:0] resp_q, tie_q, bit_mask;
  logic [CNT_W-1:0]     dbg_a_q, dbg_b_q, cnt_a, cnt_b;
  logic [NUM_RO-1:0]    sel_oh;
  logic                 settle_end, window_end, last_bit, timing;

  // SEL_W-bit addition wraps the pair index modulo NUM_RO.
  assign idx        = chal_q + k_q;
  assign sel_oh     = NUM_RO'(onehot(MAX_SEL_W'(idx)));
  assign bit_mask   = RESP_BITS'(1) << k_q;
  assign settle_end = (tmr_q == TMR_W'(SETTLE - 1));
  assign window_end = (tmr_q == TMR_W'(WINDOW - 1));
  assign last_bit   = (k_q == SEL_W'(RESP_BITS - 1));
  assign timing     = (state_q == S_SETTLE) || (state_q == S_MEASURE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_SETTLE;
      S_SETTLE:  if (settle_end) state_d = S_MEASURE;
      S_MEASURE: if (window_end) state_d = S_COMPARE;
      S_COMPARE: state_d = last_bit ? S_DONE : S_SETTLE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: decoded from registered state only, so ro_* never reach an output.
  always_comb begin
    ro_en = timing ? sel_oh : '0;
    busy  = timing || (state_q == S_COMPARE);
    done  = (state_q == S_DONE);
  end

  // Both banks share ro_en, so the same one-hot picks the counted RO in each.
  // The synchronisers track the new pair during SETTLE; counters stay cleared there.
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_i  (|(ro_a & ro_en)),
    .clr_i (state_q == S_SETTLE),
    .en_i  (state_q == S_MEASURE),
    .cnt_o (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_i  (|(ro_b & ro_en)),
    .clr_i (state_q == S_SETTLE),
    .en_i  (state_q == S_MEASURE),
    .cnt_o (cnt_b)
  );

  // Datapath: phase timer, pair index, result assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chal_q  <= '0;
      k_q     <= '0;
      tmr_q   <= '0;
      resp_q  <= '0;
      tie_q   <= '0;
      dbg_a_q <= '0;
      dbg_b_q <= '0;
    end else begin
      // Timer restarts on every state change so each phase counts from zero.
      if (timing && (state_d == state_q)) tmr_q <= tmr_q + 1'b1;
      else                                tmr_q <= '0;

      if ((state_q == S_IDLE) && start) begin
        chal_q <= challenge;
        k_q    <= '0;
        resp_q <= '0;
        tie_q  <= '0;
      end

      if (state_q == S_COMPARE) begin
        resp_q  <= resp_q | ((cnt_a > cnt_b) ? bit_mask : '0);
        tie_q   <= tie_q | ((cnt_a == cnt_b) ? bit_mask : '0);
        dbg_a_q <= cnt_a;
        dbg_b_q <= cnt_b;
        if (!last_bit) k_q <= k_q + 1'b1;
      end
    end
  end

  assign response  = resp_q;
  assign tie_mask  = tie_q;
  assign dbg_cnt_a = dbg_a_q;
  assign dbg_cnt_b = dbg_b_q;

endmodule

// File: tb/tb_ro_puf_meas_ctrl.sv
// Scoreboard bench for ro_puf_meas_ctrl: square-wave ROs, expected results from an
// edge-counting reference model pushed at start, popped by a monitor on done.
// A second instance with a 3-bit counter covers saturation on the same stimulus.
module tb_ro_puf_meas_ctrl;

  localparam int NRO    = 8;
  localparam int RB     = 4;
  localparam int WIN    = 64;
  localparam int SET    = 4;
  localparam int CW     = 8;
  localparam int CWS    = 3;
  localparam int BITLEN = SET + WIN + 1;
  localparam int RUNLEN = RB * BITLEN;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     challenge = '0;
  logic [NRO-1:0] ro_a = '0, ro_b = '0;

  logic [NRO-1:0] ro_en, ro_en_s;
  logic           busy, busy_s, done, done_s;
  logic [RB-1:0]  response, response_s, tie_mask, tie_mask_s;
  logic [CW-1:0]  dbg_cnt_a, dbg_cnt_b;
  logic [CWS-1:0] dbg_cnt_a_s, dbg_cnt_b_s;

  ro_puf_meas_ctrl #(.NUM_RO(NRO), .SEL_W(3), .CNT_W(CW), .WINDOW(WIN), .SETTLE(SET),
                     .RESP_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .busy(busy), .done(done), .response(response), .tie_mask(tie_mask),
    .dbg_cnt_a(dbg_cnt_a), .dbg_cnt_b(dbg_cnt_b));

  ro_puf_meas_ctrl #(.NUM_RO(NRO), .SEL_W(3), .CNT_W(CWS), .WINDOW(WIN), .SETTLE(SET),
                     .RESP_BITS(RB)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .response(response_s), .tie_mask(tie_mask_s),
    .dbg_cnt_a(dbg_cnt_a_s), .dbg_cnt_b(dbg_cnt_b_s));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int per_a[NRO], ph_a[NRO], per_b[NRO], ph_b[NRO];

  // RO level during clk period t (inputs change at the falling edge).
  function automatic logic wave(input int per, input int ph, input int t);
    if (per < 2) return 1'b0;
    return ((t + ph) % per) < (per / 2);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NRO; i++) begin
      ro_a[i] = wave(per_a[i], ph_a[i], cyc);
      ro_b[i] = wave(per_b[i], ph_b[i], cyc);
    end
  end

  // Rising edges at the RO pin become visible to the counter two periods later,
  // so a window of periods [m0, m0+WIN) counts pin edges whose new level is at q-2.
  function automatic int count_edges(input int per, input int ph, input int m0, input int cw);
    int c;
    c = 0;
    for (int q = m0; q < m0 + WIN; q++)
      if (wave(per, ph, q - 2) && !wave(per, ph, q - 3)) c++;
    if (c > (1 << cw) - 1) c = (1 << cw) - 1;
    return c;
  endfunction

  typedef struct {
    logic [RB-1:0] resp, tie, resp_s, tie_s;
    int            da, db, das, dbs;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0;
  bit   act = 1'b0, mon_on = 1'b0;
  int   act_p0 = 0, act_chal = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic bit model_idle();
    return !act || (cyc >= act_p0 + RUNLEN + 2);
  endfunction

  function automatic exp_t predict(input int p0, input int ch);
    exp_t e;
    int   idx, m0, ca, cb, cas, cbs;
    e = '{default: 0};
    for (int k = 0; k < RB; k++) begin
      idx = (ch + k) % NRO;
      m0  = p0 + 1 + k * BITLEN + SET;
      ca  = count_edges(per_a[idx], ph_a[idx], m0, CW);
      cb  = count_edges(per_b[idx], ph_b[idx], m0, CW);
      cas = count_edges(per_a[idx], ph_a[idx], m0, CWS);
      cbs = count_edges(per_b[idx], ph_b[idx], m0, CWS);
      e.resp[k]   = ca > cb;
      e.tie[k]    = ca == cb;
      e.resp_s[k] = cas > cbs;
      e.tie_s[k]  = cas == cbs;
      e.da = ca;  e.db = cb;  e.das = cas;  e.dbs = cbs;
    end
    return e;
  endfunction

  // Monitor: per-cycle control outputs against the run timeline, results on done.
  always @(negedge clk) begin
    int            off;
    logic          eb, ed;
    logic [NRO-1:0] ee;
    exp_t          e;
    if (mon_on) begin
      eb = 1'b0; ed = 1'b0; ee = '0;
      if (act && cyc > act_p0) begin
        off = cyc - act_p0 - 1;
        if (off < RUNLEN) begin
          eb = 1'b1;
          if (off % BITLEN < SET + WIN) ee = NRO'(1 << ((act_chal + off / BITLEN) % NRO));
        end else if (off == RUNLEN) begin
          ed = 1'b1;
        end
      end
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("ro_en", ro_en, ee);
      chk("busy_s", busy_s, eb);
      chk("done_s", done_s, ed);
      chk("ro_en_s", ro_en_s, ee);
      if (done) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done at cycle %0d: got done with no pending request", cyc);
        end else begin
          e = sbq.pop_front();
          chk("response", response, e.resp);
          chk("tie_mask", tie_mask, e.tie);
          chk("dbg_cnt_a", dbg_cnt_a, e.da);
          chk("dbg_cnt_b", dbg_cnt_b, e.db);
          chk("response_s", response_s, e.resp_s);
          chk("tie_mask_s", tie_mask_s, e.tie_s);
          chk("dbg_cnt_a_s", dbg_cnt_a_s, e.das);
          chk("dbg_cnt_b_s", dbg_cnt_b_s, e.dbs);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int ch);
    start     = 1'b1;
    challenge = 3'(ch);
    if (model_idle()) begin
      sbq.push_back(predict(cyc, ch));
      act      = 1'b1;
      act_p0   = cyc;
      act_chal = ch;
    end
    tick();
    start     = 1'b0;
    challenge = 3'($urandom);
  endtask

  task automatic wait_idle();
    while (!model_idle()) tick();
    tick();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_waves(input int pa, input int pb);
    for (int i = 0; i < NRO; i++) begin
      per_a[i] = pa; ph_a[i] = 0; per_b[i] = pb; ph_b[i] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    set_waves(8, 12);
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_response", response, 0);
    chk("rst_tie", tie_mask, 0);
    chk("rst_dbg_a", dbg_cnt_a, 0);
    chk("rst_dbg_b", dbg_cnt_b, 0);
    rst_n = 1'b1;
    tick();
    mon_on = 1'b1;

    // Basic: a faster than b on every pair
    set_waves(8, 12);
    do_start(0);
    wait_idle();
    chk("basic_response", response, 4'b1111);
    chk("basic_tie", tie_mask, 4'b0000);
    chk("basic_dbg_a", dbg_cnt_a, 8);

    // Wrap-around: pairs 6,7,0,1; b faster on 6 and 0
    set_waves(8, 12);
    per_b[6] = 6;
    per_b[0] = 6;
    do_start(6);
    wait_idle();
    chk("wrap_response", response, 4'b1010);

    // Tie: identical waves
    set_waves(8, 8);
    do_start(2);
    wait_idle();
    chk("tie_response", response, 4'b0000);
    chk("tie_mask", tie_mask, 4'b1111);
    chk("tie_dbg_a", dbg_cnt_a, 8);
    chk("tie_dbg_b", dbg_cnt_b, 8);

    // Saturation: 3-bit instance pins both counts at 7
    set_waves(4, 6);
    do_start(0);
    wait_idle();
    chk("sat_response_s", response_s, 4'b0000);
    chk("sat_tie_s", tie_mask_s, 4'b1111);
    chk("sat_dbg_a_s", dbg_cnt_a_s, 7);
    chk("sat_dbg_b_s", dbg_cnt_b_s, 7);
    chk("sat_response", response, 4'b1111);

    // Start while busy and while in DONE are ignored
    set_waves(8, 12);
    do_start(0);
    p0 = act_p0;
    wait_until(p0 + 50);
    do_start(3);
    wait_until(p0 + RUNLEN + 1);
    do_start(5);
    do_start(2);
    wait_idle();

    // Reset mid-measurement abandons the run
    do_start(1);
    wait_until(act_p0 + 100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    act = 1'b0;
    sbq.delete();
    chk("mid_rst_ro_en", ro_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_response", response, 0);
    chk("mid_rst_tie", tie_mask, 0);
    repeat (3) tick();
    do_start(4);
    wait_idle();

    // Randomised runs
    repeat (8) begin
      for (int i = 0; i < NRO; i++) begin
        per_a[i] = $urandom_range(4, 16);
        per_b[i] = $urandom_range(4, 16);
        ph_a[i]  = $urandom_range(0, per_a[i] - 1);
        ph_b[i]  = $urandom_range(0, per_b[i] - 1);
      end
      repeat ($urandom_range(0, 3)) tick();
      do_start($urandom_range(0, NRO - 1));
      p0 = act_p0;
      if ($urandom_range(0, 1) == 1) begin
        wait_until(p0 + $urandom_range(1, RUNLEN));
        do_start($urandom_range(0, NRO - 1));
      end
      wait_idle();
    end

    repeat (3) tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
